// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Multi-channel programmable clock divider. Each channel divides clk_in by
//   its own runtime divisor D. Every period it produces a one-cycle tick
//   strobe, and it toggles a square output of period 2*D. A new divisor is
//   held in a shadow register. It takes effect only at a period boundary, so
//   the divided outputs never see a runt period.
//
//   Optional feature: define CLK_DIV_SYNC_EN to add the sync_i input. sync_i
//   restarts every channel in phase and applies any pending divisor.
//
// Parameters
//   NUM_CH      number of independent channels (1..8)
//   DIV_W       divisor / counter width
//   DEFAULT_DIV divisor loaded into every channel on reset
//
// Ports
//   clk_in      system clock
//   rst         synchronous active-high reset
//   sync_i      (CLK_DIV_SYNC_EN only) phase-align all channels
//   en_i        per-channel count enable
//   load_i      per-channel divisor load strobe
//   div_i       packed divisors, channel k at [k*DIV_W +: DIV_W]
//   tick_o      per-channel one-cycle strobe, once per period
//   clk_out     per-channel square output, toggles on each tick
//   pending_o   per-channel flag: a loaded divisor awaits a boundary
module clk_div_multi #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 22,
  parameter int DEFAULT_DIV = 2083334
) (
  input  logic                    clk_in,
  input  logic                    rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic                    sync_i,
`endif
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       pending_o
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic sync_req;

  // The sync request is tied off when the feature is not built.
  // This keeps the channel logic identical in both configurations.
`ifdef CLK_DIV_SYNC_EN
  assign sync_req = sync_i;
`else
  assign sync_req = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] cnt;
    logic             tick_r;
    logic             clk_r;
    logic             pend_r;
    logic [DIV_W-1:0] div_new;
    logic             wrap;
    logic             idle;

    assign div_new = div_i[k*DIV_W +: DIV_W];

    // A wrap is the last count of a period. When D=1 the counter sits at 0,
    // so every enabled edge is a wrap, and tick stays high continuously.
    assign wrap = en_i[k] && (div_act != '0) && (cnt == div_act - ONE);

    // An idle channel has no period boundary to wait for. A pending divisor
    // is therefore applied immediately.
    assign idle = !en_i[k] || (div_act == '0);

    // Per-channel state update. The priority order is reset, then sync, then
    // wrap, then applying a pending divisor to an idle channel, then normal
    // counting. A load that arrives on a wrap edge goes straight into the
    // active divisor, so it never shows up as pending.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        div_act <= DEF_DIV;
        shadow  <= DEF_DIV;
        cnt     <= '0;
        tick_r  <= 1'b0;
        clk_r   <= 1'b0;
        pend_r  <= 1'b0;
      end else if (sync_req) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        clk_r  <= 1'b0;
        if (pend_r) begin
          div_act <= shadow;
          pend_r  <= 1'b0;
        end
      end else if (wrap) begin
        cnt    <= '0;
        tick_r <= 1'b1;
        clk_r  <= ~clk_r;
        pend_r <= 1'b0;
        if (load_i[k]) begin
          div_act <= div_new;
          shadow  <= div_new;
        end else if (pend_r) begin
          div_act <= shadow;
        end
      end else if (idle && pend_r && !load_i[k]) begin
        div_act <= shadow;
        cnt     <= '0;
        tick_r  <= 1'b0;
        pend_r  <= 1'b0;
      end else begin
        tick_r <= 1'b0;
        if (!idle) begin
          cnt <= cnt + ONE;
        end
        if (load_i[k]) begin
          shadow <= div_new;
          pend_r <= 1'b1;
        end
      end
    end

    assign tick_o[k]    = tick_r;
    assign clk_out[k]   = clk_r;
    assign pending_o[k] = pend_r;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
//   Directed bench for clk_div_multi. It uses two channels, and the reset
//   divisor is set to 5. Expected values are written per edge, counting edges
//   from the first reset release.
module tb_clk_div_multi;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 22;

  logic                    clk_in = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH-1:0]       load_i;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       pending_o;
`ifdef CLK_DIV_SYNC_EN
  logic                    sync_i;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(5)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
`ifdef CLK_DIV_SYNC_EN
    .sync_i   (sync_i),
`endif
    .en_i     (en_i),
    .load_i   (load_i),
    .div_i    (div_i),
    .tick_o   (tick_o),
    .clk_out  (clk_out),
    .pending_o(pending_o)
  );

  // Free-running system clock with a 10-unit period.
  always #5 clk_in = ~clk_in;

  // Single comparison point. It counts every check and reports each mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives the per-channel controls. Callers invoke it just after a clock
  // edge, so the next edge samples these values.
  task automatic applyStimulus(input logic [1:0] en, input logic [1:0] load,
                               input logic [DIV_W-1:0] d0, input logic [DIV_W-1:0] d1);
    en_i   = en;
    load_i = load;
    div_i  = {d1, d0};
  endtask

  // Advances one clock edge. It leaves the bench 1 unit after the edge, where
  // outputs are stable and new inputs can be driven.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst = 1'b1;
`ifdef CLK_DIV_SYNC_EN
    sync_i = 1'b0;
`endif
    applyStimulus(2'b00, 2'b00, '0, '0);
    step();
    step();
    checkOutput("rst_tick", 32'(tick_o), 32'h0);
    checkOutput("rst_clk", 32'(clk_out), 32'h0);
    checkOutput("rst_pend", 32'(pending_o), 32'h0);

    // Both channels run at the reset divisor of 5. Ticks occur at edges 5,
    // 10 and 15, and clk_out toggles on each tick.
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00, '0, '0);
    for (int e = 1; e <= 15; e++) begin
      step();
      checkOutput("p1_tick", 32'(tick_o), (e % 5 == 0) ? 32'h3 : 32'h0);
      checkOutput("p1_clk", 32'(clk_out), ((e / 5) % 2 == 1) ? 32'h3 : 32'h0);
      checkOutput("p1_pend", 32'(pending_o), 32'h0);
    end

    // Edge 16 puts ch0 at cnt=1. Loading 3 there leaves it pending until the
    // wrap at edge 20. Ch0 then ticks every 3 cycles, while ch1 keeps D=5.
    step();
    applyStimulus(2'b11, 2'b01, 22'd3, '0);
    step();
    applyStimulus(2'b11, 2'b00, '0, '0);
    checkOutput("ld_pend17", 32'(pending_o[0]), 32'h1);
    step();
    checkOutput("ld_pend18", 32'(pending_o[0]), 32'h1);
    step();
    checkOutput("ld_pend19", 32'(pending_o[0]), 32'h1);
    checkOutput("ld_tick19", 32'(tick_o[0]), 32'h0);
    step();
    checkOutput("ld_pend20", 32'(pending_o[0]), 32'h0);
    checkOutput("ld_tick20", 32'(tick_o[0]), 32'h1);
    checkOutput("ld_clk20", 32'(clk_out[0]), 32'h0);
    for (int e = 21; e <= 26; e++) begin
      step();
      checkOutput("ld_tick", 32'(tick_o), {30'b0, (e % 5 == 0), (e == 23 || e == 26)});
      checkOutput("ld_clk", 32'(clk_out), {30'b0, (e >= 25), (e >= 23 && e < 26)});
    end

    // Ch0 is disabled right after its wrap (cnt=0) for 7 edges. It holds its
    // state through the pause, then ticks 3 edges after re-enable.
    applyStimulus(2'b10, 2'b00, '0, '0);
    for (int e = 27; e <= 33; e++) begin
      step();
      checkOutput("dis_tick", 32'(tick_o[0]), 32'h0);
      checkOutput("dis_clk", 32'(clk_out[0]), 32'h0);
    end
    applyStimulus(2'b11, 2'b00, '0, '0);
    for (int e = 34; e <= 36; e++) begin
      step();
      checkOutput("reen_tick", 32'(tick_o[0]), (e == 36) ? 32'h1 : 32'h0);
      checkOutput("reen_clk", 32'(clk_out[0]), (e == 36) ? 32'h1 : 32'h0);
    end

    // Divisor 1 is loaded on the wrap edge (39), so it applies directly and
    // pending never rises. After that, tick stays high and clk_out toggles
    // every edge.
    step();
    step();
    applyStimulus(2'b11, 2'b01, 22'd1, '0);
    step();
    applyStimulus(2'b11, 2'b00, '0, '0);
    checkOutput("d1_tick39", 32'(tick_o[0]), 32'h1);
    checkOutput("d1_clk39", 32'(clk_out[0]), 32'h0);
    checkOutput("d1_pend39", 32'(pending_o[0]), 32'h0);
    for (int e = 40; e <= 43; e++) begin
      step();
      checkOutput("d1_tick", 32'(tick_o[0]), 32'h1);
      checkOutput("d1_clk", 32'(clk_out[0]), (e % 2 == 0) ? 32'h1 : 32'h0);
    end

    // Divisor 0, also loaded on a wrap, halts ch0. There are no ticks after
    // edge 44, and clk_out stays frozen at 1.
    applyStimulus(2'b11, 2'b01, 22'd0, '0);
    step();
    applyStimulus(2'b11, 2'b00, '0, '0);
    checkOutput("d0_tick44", 32'(tick_o[0]), 32'h1);
    checkOutput("d0_clk44", 32'(clk_out[0]), 32'h1);
    for (int e = 45; e <= 49; e++) begin
      step();
      checkOutput("d0_tick", 32'(tick_o[0]), 32'h0);
      checkOutput("d0_clk", 32'(clk_out[0]), 32'h1);
      checkOutput("d0_pend", 32'(pending_o[0]), 32'h0);
    end

    // Divisor 4 is loaded while ch0 is halted. It goes pending at edge 50 and
    // is applied at edge 51 with cnt=0. Ticks then follow at edges 55 and 59.
    applyStimulus(2'b11, 2'b01, 22'd4, '0);
    step();
    applyStimulus(2'b11, 2'b00, '0, '0);
    checkOutput("d4_pend50", 32'(pending_o[0]), 32'h1);
    checkOutput("d4_tick50", 32'(tick_o[0]), 32'h0);
    step();
    checkOutput("d4_pend51", 32'(pending_o[0]), 32'h0);
    checkOutput("d4_clk51", 32'(clk_out[0]), 32'h1);
    for (int e = 52; e <= 59; e++) begin
      step();
      checkOutput("d4_tick", 32'(tick_o[0]), (e == 55 || e == 59) ? 32'h1 : 32'h0);
      checkOutput("d4_clk", 32'(clk_out[0]), (e < 55 || e >= 59) ? 32'h1 : 32'h0);
    end

    // Reset is asserted while a load of 7 is pending. The load is discarded,
    // both channels restart at D=5 and tick at edges 67 and 72, and edge 69
    // stays quiet.
    step();
    applyStimulus(2'b11, 2'b01, 22'd7, '0);
    step();
    applyStimulus(2'b11, 2'b00, '0, '0);
    checkOutput("rp_pend61", 32'(pending_o[0]), 32'h1);
    rst = 1'b1;
    step();
    checkOutput("rp_tick", 32'(tick_o), 32'h0);
    checkOutput("rp_clk", 32'(clk_out), 32'h0);
    checkOutput("rp_pend", 32'(pending_o), 32'h0);
    rst = 1'b0;
    for (int e = 63; e <= 72; e++) begin
      step();
      checkOutput("rp_tick", 32'(tick_o), (e == 67 || e == 72) ? 32'h3 : 32'h0);
      checkOutput("rp_clk", 32'(clk_out), (e >= 67 && e < 72) ? 32'h3 : 32'h0);
      checkOutput("rp_pendx", 32'(pending_o), 32'h0);
    end

`ifdef CLK_DIV_SYNC_EN
    // Ch0 gets D=4 and ch1 gets D=6 while both are disabled. They run out of
    // phase for 5 edges, then sync_i realigns them. Afterwards ch0 ticks
    // every 4 edges, ch1 every 6, and they coincide at 12.
    applyStimulus(2'b00, 2'b11, 22'd4, 22'd6);
    step();
    applyStimulus(2'b00, 2'b00, '0, '0);
    checkOutput("sy_pend", 32'(pending_o), 32'h3);
    step();
    checkOutput("sy_apply", 32'(pending_o), 32'h0);
    applyStimulus(2'b11, 2'b00, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      step();
    end
    checkOutput("sy_clk_pre", 32'(clk_out), 32'h1);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    checkOutput("sy_tick", 32'(tick_o), 32'h0);
    checkOutput("sy_clk", 32'(clk_out), 32'h0);
    for (int i = 1; i <= 12; i++) begin
      step();
      checkOutput("sy_run", 32'(tick_o), {30'b0, (i % 6 == 0), (i % 4 == 0)});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
